// File: rtl/sysid_reader_pkg.sv
// Shared types and constants for the system-ID reader: FSM encodings, word
// addresses and the timeout counter width.
package sysid_reader_pkg;

    localparam int unsigned CNT_W = 16;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StReqId,
        StWaitId,
        StReqTs,
        StWaitTs,
        StFinish
    } state_e;

    typedef enum logic [1:0] {
        PortIdle,
        PortReq,
        PortWait
    } port_state_e;

    // Counter value at which a word is abandoned.
    function automatic logic [CNT_W-1:0] last_count(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sysid_reader_if.sv
// Avalon-MM read-only bus between the reader (master) and the system-ID slave.
interface sysid_reader_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );

endinterface

// File: rtl/sysid_read_port.sv
// Single-word Avalon read: issues one read on i_go, reports the returned word or a
// timeout. Bus outputs are registered; o_valid/o_timed_out are same-cycle strobes.
module sysid_read_port
    import sysid_reader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_go,
    input  logic               i_address,
    output logic [31:0]        o_data,
    output logic               o_valid,
    output logic               o_accept,
    output logic               o_timed_out,
    sysid_reader_if.master     avm
);

    localparam logic [CNT_W-1:0] LastCount = last_count(TIMEOUT_CYCLES);

    port_state_e      r_state;
    logic             r_read;
    logic             r_address;
    logic [CNT_W-1:0] r_count;

    logic w_active;
    logic w_accept;
    logic w_valid;
    logic w_timed_out;

    assign w_active    = (r_state != PortIdle);
    assign w_accept    = (r_state == PortReq) && !avm.avm_waitrequest;
    // Data in the accept cycle covers zero-latency fabrics.
    assign w_valid     = avm.avm_readdatavalid && (w_accept || (r_state == PortWait));
    assign w_timed_out = w_active && !w_valid && (r_count == LastCount);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= PortIdle;
            r_read    <= 1'b0;
            r_address <= 1'b0;
            r_count   <= '0;
        end else if (i_go) begin
            r_state   <= PortReq;
            r_read    <= 1'b1;
            r_address <= i_address;
            r_count   <= '0;
        end else if (w_active) begin
            r_count <= r_count + 1'b1;
            if (w_valid || w_timed_out) begin
                r_state <= PortIdle;
                r_read  <= 1'b0;
            end else if (w_accept) begin
                r_state <= PortWait;
                r_read  <= 1'b0;
            end
        end
    end

    assign avm.avm_read    = r_read;
    assign avm.avm_address = r_address;

    assign o_data      = avm.avm_readdata;
    assign o_valid     = w_valid;
    assign o_accept    = w_accept;
    assign o_timed_out = w_timed_out;

endmodule

// File: rtl/sysid_reader.sv
// Reads system-ID word 0 (ID) then word 1 (timestamp) and compares them with the
// build-time values so software can refuse to run on a mismatched hardware image.
module sysid_reader
    import sysid_reader_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1353400164,
    parameter int unsigned TIMEOUT_CYCLES     = 1024,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    sysid_reader_if.master avm,
    output logic           busy,
    output logic           done,
    output logic           id_ok,
    output logic           ts_ok,
    output logic           timeout_err,
    output logic [31:0]    id_value,
    output logic [31:0]    ts_value
);

    state_e      r_state;
    logic        r_auto;
    logic        r_busy;
    logic        r_done;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout_err;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic        w_launch;
    logic        w_id_phase;
    logic        w_ts_phase;
    logic        w_go;
    logic        w_go_addr;
    logic [31:0] w_data;
    logic        w_valid;
    logic        w_accept;
    logic        w_timed_out;

    assign w_launch   = (r_state == StIdle) && (start || r_auto);
    assign w_id_phase = (r_state == StReqId) || (r_state == StWaitId);
    assign w_ts_phase = (r_state == StReqTs) || (r_state == StWaitTs);
    // The timestamp read is issued in the same cycle the ID word lands.
    assign w_go       = w_launch || (w_id_phase && w_valid);
    assign w_go_addr  = w_launch ? ADDR_ID : ADDR_TS;

    sysid_read_port #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_port (
        .clock      (clock),
        .reset      (reset),
        .i_go       (w_go),
        .i_address  (w_go_addr),
        .o_data     (w_data),
        .o_valid    (w_valid),
        .o_accept   (w_accept),
        .o_timed_out(w_timed_out),
        .avm        (avm)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= StIdle;
            r_auto        <= AUTO_START;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_launch) begin
                        r_state       <= StReqId;
                        r_busy        <= 1'b1;
                        r_auto        <= 1'b0;
                        r_id_ok       <= 1'b0;
                        r_ts_ok       <= 1'b0;
                        r_timeout_err <= 1'b0;
                    end
                end
                StReqId, StWaitId: begin
                    if (w_valid) begin
                        r_id_value <= w_data;
                        r_id_ok    <= (w_data == EXPECTED_ID);
                        r_state    <= StReqTs;
                    end else if (w_timed_out) begin
                        r_timeout_err <= 1'b1;
                        r_done        <= 1'b1;
                        r_state       <= StFinish;
                    end else if ((r_state == StReqId) && w_accept) begin
                        r_state <= StWaitId;
                    end
                end
                StReqTs, StWaitTs: begin
                    if (w_valid) begin
                        r_ts_value <= w_data;
                        r_ts_ok    <= (w_data == EXPECTED_TIMESTAMP);
                        r_done     <= 1'b1;
                        r_state    <= StFinish;
                    end else if (w_timed_out) begin
                        r_timeout_err <= 1'b1;
                        r_done        <= 1'b1;
                        r_state       <= StFinish;
                    end else if ((r_state == StReqTs) && w_accept) begin
                        r_state <= StWaitTs;
                    end
                end
                StFinish: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout_err = r_timeout_err;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule
